// File: rtl/pwm_pkg.sv
// rtl/pwm_pkg.sv - shared types and width helpers for multi_pwm_fader
//
// Contents:
//   fsm_state_t  rainbow sequencer state (IDLE, SEED, HUE; the HUE index k
//                is held in a separate counter in the top level)
//   width_of(n)  bits needed to index 0..n-1, never less than 1
//   duty_max(r)  largest duty code for an r-bit PWM (2^r - 1)
package pwm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEED,
    ST_HUE
  } fsm_state_t;

  function automatic int width_of(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int duty_max(input int r);
    return (1 << r) - 1;
  endfunction

endpackage

// File: rtl/pwm_channel.sv
// rtl/pwm_channel.sv - one PWM channel: fade register, duty latch, gamma, comparator
//
// Optional feature macro: PWM_GAMMA_EN (square-law duty correction).
//
// Ports:
//   clk, rst_n  system clock, asynchronous active-low reset
//   step        fade step strobe; duty_cur moves 1 toward duty_tgt
//   boundary    PWM period boundary; latches the effective duty
//   cnt         shared PWM counter
//   tgt_we      load duty_tgt from tgt_val
//   tgt_val     new target duty
//   freeze      set duty_tgt to the value duty_cur takes this clock
//   pwm         registered PWM output
//   busy        duty_cur differs from duty_tgt
module pwm_channel
  import pwm_pkg::*;
#(
  parameter int R = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         step,
  input  logic         boundary,
  input  logic [R-1:0] cnt,
  input  logic         tgt_we,
  input  logic [R-1:0] tgt_val,
  input  logic         freeze,
  output logic         pwm,
  output logic         busy
);

  localparam logic [R-1:0] ONE = {{(R-1){1'b0}}, 1'b1};

  logic [R-1:0] duty_cur;
  logic [R-1:0] duty_tgt;
  logic [R-1:0] duty_act;
  logic [R-1:0] cur_next;
  logic [R-1:0] duty_eff;

  // Step compares against the registered target, so a write landing in the
  // same clock as a step only takes effect from the following clock.
  always_comb begin
    cur_next = duty_cur;
    if (step && (duty_cur < duty_tgt)) begin
      cur_next = duty_cur + ONE;
    end else if (step && (duty_cur > duty_tgt)) begin
      cur_next = duty_cur - ONE;
    end
  end

`ifdef PWM_GAMMA_EN
  logic [2*R-1:0] duty_sq;
  assign duty_sq  = {{R{1'b0}}, duty_cur} * {{R{1'b0}}, duty_cur};
  assign duty_eff = duty_sq[2*R-1:R];
`else
  assign duty_eff = duty_cur;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      duty_cur <= '0;
      duty_tgt <= '0;
      duty_act <= '0;
      pwm      <= 1'b0;
    end else begin
      duty_cur <= cur_next;
      // Freezing to cur_next (not duty_cur) keeps busy low even if a step
      // coincides with the freeze.
      if (tgt_we) begin
        duty_tgt <= tgt_val;
      end else if (freeze) begin
        duty_tgt <= cur_next;
      end
      if (boundary) begin
        duty_act <= duty_eff;
      end
      pwm <= (cnt < duty_act);
    end
  end

  assign busy = (duty_cur != duty_tgt);

endmodule

// File: rtl/multi_pwm_fader.sv
// rtl/multi_pwm_fader.sv - N-channel PWM with linear fade and rainbow sweep
//
// Optional feature macro: PWM_GAMMA_EN (square-law duty correction per channel).
//
// Ports:
//   clk, rst_n  system clock, asynchronous active-low reset
//   mode        0 = host-loaded targets, 1 = autonomous rainbow sweep
//   tgt_valid   target write request; tgt_ready = ~mode
//   tgt_ch      channel of the write (values >= N are accepted and dropped)
//   tgt_duty    target duty of the write
//   pwm_out     registered PWM outputs, one per channel
//   busy        per-channel fade in progress
//   sync_out    one-clock pulse when the PWM counter wraps to 0
module multi_pwm_fader
  import pwm_pkg::*;
#(
  parameter int N           = 3,
  parameter int R           = 8,
  parameter int DVSR        = 100,
  parameter int GRAD_THRESH = 1000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 mode,
  input  logic                 tgt_valid,
  output logic                 tgt_ready,
  input  logic [$clog2(N)-1:0] tgt_ch,
  input  logic [R-1:0]         tgt_duty,
  output logic [N-1:0]         pwm_out,
  output logic [N-1:0]         busy,
  output logic                 sync_out
);

  localparam int CH_W   = width_of(N);
  localparam int PRE_W  = width_of(DVSR);
  localparam int STEP_W = width_of(GRAD_THRESH);
  localparam int HUE_W  = width_of(2 * N);
  localparam logic [R-1:0] DMAX = R'(duty_max(R));

  // HUE(2j) raises channel (j+1) mod N, HUE(2j+1) lowers channel j.
  function automatic int hue_channel(input int k);
    if ((k % 2) == 0) begin
      return ((k / 2) + 1) % N;
    end
    return k / 2;
  endfunction

  logic [PRE_W-1:0]  pre;
  logic [R-1:0]      cnt;
  logic [STEP_W-1:0] step_cnt;
  logic              tick;
  logic              boundary;
  logic              step;

  assign tick     = (pre == PRE_W'(DVSR - 1));
  assign boundary = tick && (cnt == DMAX);
  assign step     = (step_cnt == STEP_W'(GRAD_THRESH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre      <= '0;
      cnt      <= '0;
      step_cnt <= '0;
      sync_out <= 1'b0;
    end else begin
      pre      <= tick ? '0 : pre + PRE_W'(1);
      step_cnt <= step ? '0 : step_cnt + STEP_W'(1);
      if (tick) begin
        cnt <= cnt + R'(1);
      end
      sync_out <= boundary;
    end
  end

  // Rainbow sequencer
  fsm_state_t       state, state_nxt;
  logic [HUE_W-1:0] hue, hue_nxt;
  logic [CH_W-1:0]  cur_ch, nxt_ch;
  logic             seed;
  logic             hue_we;
  logic             freeze;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      hue   <= '0;
    end else begin
      state <= state_nxt;
      hue   <= hue_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    hue_nxt   = hue;
    seed      = 1'b0;
    hue_we    = 1'b0;
    freeze    = 1'b0;
    nxt_ch    = '0;
    cur_ch    = CH_W'(hue_channel(int'(hue)));
    case (state)
      ST_IDLE: begin
        if (mode) begin
          state_nxt = ST_SEED;
          seed      = 1'b1;
        end
      end
      ST_SEED: begin
        if (!mode) begin
          state_nxt = ST_IDLE;
          freeze    = 1'b1;
        end else if (busy == '0) begin
          state_nxt = ST_HUE;
          hue_nxt   = '0;
          hue_we    = 1'b1;
        end
      end
      ST_HUE: begin
        if (!mode) begin
          state_nxt = ST_IDLE;
          freeze    = 1'b1;
        end else if (!busy[cur_ch]) begin
          hue_nxt = (hue == HUE_W'(2 * N - 1)) ? '0 : hue + HUE_W'(1);
          hue_we  = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
    // Target of the state being entered is loaded on the advance edge so
    // busy already reflects it on the first clock of the new state.
    nxt_ch = CH_W'(hue_channel(int'(hue_nxt)));
  end

  // Target write steering: host writes only exist with mode = 0, sequencer
  // writes only with mode = 1, so at most one source is active per channel.
  logic          wr_acc;
  logic [N-1:0]  ch_we;
  logic [R-1:0]  ch_val [N];

  assign tgt_ready = ~mode;
  assign wr_acc    = tgt_valid & tgt_ready;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      ch_we[i]  = 1'b0;
      ch_val[i] = '0;
      if (wr_acc && (int'(tgt_ch) == i)) begin
        ch_we[i]  = 1'b1;
        ch_val[i] = tgt_duty;
      end else if (seed) begin
        ch_we[i]  = 1'b1;
        ch_val[i] = (i == 0) ? DMAX : '0;
      end else if (hue_we && (int'(nxt_ch) == i)) begin
        ch_we[i]  = 1'b1;
        ch_val[i] = hue_nxt[0] ? '0 : DMAX;
      end
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_ch
    pwm_channel #(.R(R)) u_ch (
      .clk      (clk),
      .rst_n    (rst_n),
      .step     (step),
      .boundary (boundary),
      .cnt      (cnt),
      .tgt_we   (ch_we[i]),
      .tgt_val  (ch_val[i]),
      .freeze   (freeze),
      .pwm      (pwm_out[i]),
      .busy     (busy[i])
    );
  end

endmodule

// File: doc/multi_pwm_fader.md
# multi_pwm_fader

Parametrised N-channel PWM generator with a per-channel linear fade engine and two modes: host-loaded targets through a valid/ready handshake, or an autonomous hue-wheel sweep generalised from the three-channel rainbow. It is the next generation of the RGB PWM driver and sits between the system clock domain and the LED/pad outputs. Duty changes take effect only at PWM period boundaries, so outputs are glitch-free.

## Interface
- `N`, 3, number of channels (≥2)
- `R`, 8, PWM resolution in bits; period = 2^R PWM ticks
- `DVSR`, 100, clk cycles per PWM tick (≥1)
- `GRAD_THRESH`, 1000, clk cycles per fade step (≥1)
- `clk`  in  1  system clock
- `rst_n`  in  1  reset, asynchronous assert, active-low
- `mode`  in  1  0 = manual targets, 1 = rainbow sweep
- `tgt_valid`  in  1  target write request
- `tgt_ready`  out  1  target write accept (combinational: `~mode`)
- `tgt_ch`  in  $clog2(N)  channel index of write
- `tgt_duty`  in  R  target duty of write
- `pwm_out`  out  N  registered PWM outputs
- `busy`  out  N  channel i fading (`duty_cur[i] != duty_tgt[i]`)
- `sync_out`  out  1  one-clk pulse on the clock where the PWM counter wraps to 0

## Operation
- Prescaler counts 0..DVSR-1; tick when count = DVSR-1. PWM counter `cnt` (R bits) increments per tick, wraps 2^R-1 → 0.
- Period boundary = tick with `cnt` = 2^R-1: `duty_act[i] <= duty_eff(duty_cur[i])`; `sync_out` pulses that clock.
- `pwm_out[i] <= (cnt < duty_act[i])`. Duty 0: constantly low. Duty 2^R-1: low one tick per period. 100% is not reachable.
- Step counter counts 0..GRAD_THRESH-1; step pulse at terminal count. On a step, every channel with `duty_cur != duty_tgt` moves by exactly 1 toward `duty_tgt`; no overshoot, no wrap.
- Manual mode: write accepted when `tgt_valid & tgt_ready`; sets `duty_tgt[tgt_ch] <= tgt_duty`. `tgt_ch` ≥ N: accepted and dropped. Retarget mid-fade continues from current `duty_cur` (no jump).
- Rainbow FSM states: IDLE, SEED, HUE(k), k = 0..2N-1.
  - IDLE: manual mode. `mode` rising → SEED: targets = {2^R-1, 0, …, 0}.
  - SEED → HUE(0) when all `busy` low.
  - HUE(2j): target of channel (j+1) mod N = 2^R-1. HUE(2j+1): target of channel j = 0. Advance to HUE((k+1) mod 2N) on the clock after that channel's `busy` is low.
  - For N = 3 this is R↑G, R↓, B↑, G↓, R↑, B↓.
  - `mode` falling (any state) → IDLE; all `duty_tgt <= duty_cur` (fade freezes).
- Simultaneous events: write and step in the same clock use the old target for that step; the new target applies from the next clock. A mode change in the same clock as a write: write accepted only if `mode` = 0 that clock.

## Timing
- Reset (async, `rst_n` low): prescaler, `cnt`, step counter = 0; `duty_cur`/`duty_tgt`/`duty_act` = 0; `pwm_out` = 0, `busy` = 0, `sync_out` = 0; FSM IDLE. Mid-operation reset forces all outputs low immediately. Fade and PWM restart from zero on release.
- `pwm_out` lags `cnt` by one clk. Period = DVSR·2^R clk.
- Write → `busy` high the next clk. First step within GRAD_THRESH clk. Each step is visible on `pwm_out` at the next period boundary + 1 clk.
- Full fade of Δ counts = Δ·GRAD_THRESH clk, ±GRAD_THRESH.
- Rainbow loop ≈ 2N·(2^R-1)·GRAD_THRESH clk plus one advance clk per state.

## Configuration
- `PWM_GAMMA_EN` defined: `duty_eff(d) = (d·d) >> R` (2R-bit product, registered into `duty_act` at the period boundary).
- Undefined: `duty_eff(d) = d`. No multiplier is synthesised.

## Structure
- Package `pwm_pkg`: FSM state typedef, `CH_W = $clog2(N)`-style width helpers, `DUTY_MAX` constant function.
- Sub-module `pwm_channel`: per-channel fade register, duty latch, gamma path and comparator. Instantiated N times. Prescaler, step counter, FSM and handshake stay in the top level.

## Test plan
Bench parameters: N=3, R=8, DVSR=4, GRAD_THRESH=2.
- Reset: pulse `rst_n` low mid-sweep → `pwm_out`=0, `busy`=0, `sync_out`=0 in the same clk; after release the first `sync_out` arrives 1024 clk later.
- Manual write ch0=64 → `busy[0]` high ≈128 clk. After settling, `pwm_out[0]` is high exactly 256 of every 1024 clk.
- Boundaries: ch1=0 → `pwm_out[1]` never high. ch1=255 → low exactly 4 clk per period. `tgt_ch`=3 → no channel changes.
- Retarget: ch2→200, then write ch2=10 when `duty_cur`=50 → monotonic ramp down from 50 to 10. No high-time jump across boundaries.
- Rainbow: `mode`=1 → `tgt_ready`=0, writes ignored. SEED drives ch0 to 255. States HUE(0..5) occur in order with the described targets and the sequence returns to HUE(0). `mode`=0 mid-HUE(2) → duties freeze.
- Gamma: with `PWM_GAMMA_EN`, ch0=128 → high 256 clk/period. Without it → 512 clk/period.
